// File: rtl/tff_counter_param.sv
// tff_counter_param
// WIDTH-bit up/down counter with a programmable terminal value, synchronous
// parallel load, wrap or one-shot (halt) behaviour and a one-cycle
// terminal-count pulse. The count is also shown on active-low 7-segment
// hex digits, so the block can sit between board switches and HEX displays.
module tff_counter_param #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter bit              ONE_SHOT = 1'b0,
  localparam int             DIGITS   = (WIDTH + 3) / 4
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  Enable,
  input  logic                  Up,
  input  logic                  Load,
  input  logic [WIDTH-1:0]      LoadValue,
  output logic [WIDTH-1:0]      Count,
  output logic                  TC,
  output logic                  Halted,
  output logic [7*DIGITS-1:0]   HEX
);

  // Terminal value at counter width; MAX is required to fit in WIDTH bits
  localparam logic [WIDTH-1:0] MAXV = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONEV = WIDTH'(1);

  logic [WIDTH-1:0]    nextCount;
  logic                nextTc;
  logic                nextHalted;
  logic [WIDTH-1:0]    loadClamped;
  logic                atTerminal;
  logic [4*DIGITS-1:0] paddedCount;

  // Active-low glyph for one hex nibble; bit 6 is segment a, bit 0 is segment g
  function automatic logic [6:0] hexGlyph(input logic [3:0] nibble);
    logic [6:0] glyph;
    glyph = 7'h7F;
    case (nibble)
      4'h0: glyph = 7'h01;
      4'h1: glyph = 7'h4F;
      4'h2: glyph = 7'h12;
      4'h3: glyph = 7'h06;
      4'h4: glyph = 7'h4C;
      4'h5: glyph = 7'h24;
      4'h6: glyph = 7'h20;
      4'h7: glyph = 7'h0F;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h04;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h60;
      4'hC: glyph = 7'h31;
      4'hD: glyph = 7'h42;
      4'hE: glyph = 7'h30;
      4'hF: glyph = 7'h38;
      default: glyph = 7'h7F;
    endcase
    return glyph;
  endfunction

  // Loads above the terminal value saturate so the count never leaves 0..MAX
  always_comb begin
    loadClamped = (LoadValue > MAXV) ? MAXV : LoadValue;
  end

  // Terminal detection depends on direction: MAX going up, zero going down
  always_comb begin
    atTerminal = Up ? (Count >= MAXV) : (Count == '0);
  end

  // Next-state rules: load beats counting, halted counters ignore Enable,
  // and wrap is an explicit compare so non-power-of-two MAX works
  always_comb begin
    nextCount  = Count;
    nextTc     = 1'b0;
    nextHalted = Halted;
    if (Load) begin
      nextCount  = loadClamped;
      nextHalted = 1'b0;
      nextTc     = 1'b0;
    end else if (Enable && !Halted) begin
      if (atTerminal) begin
        nextTc = 1'b1;
        if (ONE_SHOT) begin
          nextHalted = 1'b1;
        end else begin
          nextCount = Up ? '0 : MAXV;
        end
      end else begin
        nextCount = Up ? (Count + ONEV) : (Count - ONEV);
      end
    end
  end

  // State registers; Clear forces everything to zero immediately
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      Count  <= '0;
      TC     <= 1'b0;
      Halted <= 1'b0;
    end else begin
      Count  <= nextCount;
      TC     <= nextTc;
      Halted <= nextHalted;
    end
  end

  // Zero-pad the count up to a whole number of nibbles for the display
  always_comb begin
    paddedCount              = '0;
    paddedCount[WIDTH-1:0]   = Count;
  end

  // One combinational decoder per display digit, digit k at HEX[7k+:7]
  always_comb begin
    HEX = '0;
    for (int k = 0; k < DIGITS; k++) begin
      HEX[7*k +: 7] = hexGlyph(paddedCount[4*k +: 4]);
    end
  end

endmodule

// File: tb/tb_tff_counter_param.sv
// tb_tff_counter_param
// Drives six differently configured counters from shared stimulus and
// compares every one against an arithmetic model on each falling edge.
module tb_tff_counter_param;

  localparam int N = 6;

  // Per-instance configuration: width, terminal value, one-shot mode
  int              cfgWidth  [N] = '{8, 4, 4, 8, 10, 3};
  longint unsigned cfgMax    [N] = '{255, 9, 5, 150, 1023, 0};
  bit              cfgOneShot[N] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  // Lit segments for each hex glyph, named by segment letter
  string litSegs[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                         "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                         "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  logic       Clock;
  logic       Clear;
  logic       Enable;
  logic       Up;
  logic       Load;
  logic [9:0] LoadValue;

  logic [7:0]  cnt0;  logic [13:0] hex0;
  logic [3:0]  cnt1;  logic [6:0]  hex1;
  logic [3:0]  cnt2;  logic [6:0]  hex2;
  logic [7:0]  cnt3;  logic [13:0] hex3;
  logic [9:0]  cnt4;  logic [20:0] hex4;
  logic [2:0]  cnt5;  logic [6:0]  hex5;
  logic [N-1:0] tcv;
  logic [N-1:0] hltv;

  logic [31:0] dCount[N];
  logic [27:0] dHex  [N];

  longint unsigned mCount[N];
  bit              mTc   [N];
  bit              mHalt [N];

  int checkCount = 0;
  int passCount  = 0;

  tff_counter_param #(.WIDTH(8)) u0 (
    .Clock(Clock), .Clear(Clear), .Enable(Enable), .Up(Up), .Load(Load),
    .LoadValue(LoadValue[7:0]), .Count(cnt0), .TC(tcv[0]), .Halted(hltv[0]), .HEX(hex0));
  tff_counter_param #(.WIDTH(4), .MAX(9)) u1 (
    .Clock(Clock), .Clear(Clear), .Enable(Enable), .Up(Up), .Load(Load),
    .LoadValue(LoadValue[3:0]), .Count(cnt1), .TC(tcv[1]), .Halted(hltv[1]), .HEX(hex1));
  tff_counter_param #(.WIDTH(4), .MAX(5), .ONE_SHOT(1'b1)) u2 (
    .Clock(Clock), .Clear(Clear), .Enable(Enable), .Up(Up), .Load(Load),
    .LoadValue(LoadValue[3:0]), .Count(cnt2), .TC(tcv[2]), .Halted(hltv[2]), .HEX(hex2));
  tff_counter_param #(.WIDTH(8), .MAX(150)) u3 (
    .Clock(Clock), .Clear(Clear), .Enable(Enable), .Up(Up), .Load(Load),
    .LoadValue(LoadValue[7:0]), .Count(cnt3), .TC(tcv[3]), .Halted(hltv[3]), .HEX(hex3));
  tff_counter_param #(.WIDTH(10)) u4 (
    .Clock(Clock), .Clear(Clear), .Enable(Enable), .Up(Up), .Load(Load),
    .LoadValue(LoadValue), .Count(cnt4), .TC(tcv[4]), .Halted(hltv[4]), .HEX(hex4));
  tff_counter_param #(.WIDTH(3), .MAX(0)) u5 (
    .Clock(Clock), .Clear(Clear), .Enable(Enable), .Up(Up), .Load(Load),
    .LoadValue(LoadValue[2:0]), .Count(cnt5), .TC(tcv[5]), .Halted(hltv[5]), .HEX(hex5));

  assign dCount[0] = 32'(cnt0);  assign dHex[0] = 28'(hex0);
  assign dCount[1] = 32'(cnt1);  assign dHex[1] = 28'(hex1);
  assign dCount[2] = 32'(cnt2);  assign dHex[2] = 28'(hex2);
  assign dCount[3] = 32'(cnt3);  assign dHex[3] = 28'(hex3);
  assign dCount[4] = 32'(cnt4);  assign dHex[4] = 28'(hex4);
  assign dCount[5] = 32'(cnt5);  assign dHex[5] = 28'(hex5);

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Expected display: build each digit from its list of lit segment letters
  function automatic logic [27:0] modelHex(input longint unsigned v, input int digits);
    logic [27:0]     h;
    logic [6:0]      g;
    longint unsigned nib;
    string           s;
    h = '0;
    for (int k = 0; k < digits; k++) begin
      nib = (v >> (4 * k)) & 64'd15;
      s   = litSegs[int'(nib)];
      g   = 7'h7F;
      for (int j = 0; j < s.len(); j++) begin
        g[6 - (int'(s[j]) - 97)] = 1'b0;
      end
      h[7*k +: 7] = g;
    end
    return h;
  endfunction

  // Reference model: counts as modular arithmetic over 0..MAX
  always @(posedge Clock or posedge Clear) begin
    longint unsigned lvi;
    bit              terminal;
    for (int i = 0; i < N; i++) begin
      if (Clear) begin
        mCount[i] <= 0;
        mTc[i]    <= 1'b0;
        mHalt[i]  <= 1'b0;
      end else if (Load) begin
        lvi       = longint'(LoadValue) & ((64'd1 << cfgWidth[i]) - 64'd1);
        mCount[i] <= (lvi > cfgMax[i]) ? cfgMax[i] : lvi;
        mTc[i]    <= 1'b0;
        mHalt[i]  <= 1'b0;
      end else if (Enable && !mHalt[i]) begin
        terminal = Up ? (mCount[i] == cfgMax[i]) : (mCount[i] == 0);
        mTc[i]  <= terminal;
        if (terminal && cfgOneShot[i])
          mHalt[i] <= 1'b1;
        else if (Up)
          mCount[i] <= (mCount[i] + 1) % (cfgMax[i] + 1);
        else
          mCount[i] <= (mCount[i] + cfgMax[i]) % (cfgMax[i] + 1);
      end else begin
        mTc[i] <= 1'b0;
      end
    end
  end

  // One comparison with pass/fail bookkeeping
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    else
      passCount++;
  endtask

  // Every falling edge, all instances must match the model
  always @(negedge Clock) begin
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("u%0d.Count", i), dCount[i], 32'(mCount[i]));
      checkOutput($sformatf("u%0d.TC", i), 32'(tcv[i]), 32'(mTc[i]));
      checkOutput($sformatf("u%0d.Halted", i), 32'(hltv[i]), 32'(mHalt[i]));
      checkOutput($sformatf("u%0d.HEX", i), 32'(dHex[i]),
                  32'(modelHex(mCount[i], (cfgWidth[i] + 3) / 4)));
    end
  end

  // Drive one cycle of inputs, then return at the following falling edge
  task automatic applyStimulus(input logic en, input logic up, input logic ld,
                               input logic [9:0] lv);
    Enable    = en;
    Up        = up;
    Load      = ld;
    LoadValue = lv;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic doClear();
    Clear = 1'b1;
    Enable = 1'b0;
    Load = 1'b0;
    @(negedge Clock);
    Clear = 1'b0;
  endtask

  initial begin
    Clear = 1'b0; Enable = 1'b0; Up = 1'b1; Load = 1'b0; LoadValue = '0;
    @(negedge Clock);
    doClear();
    checkOutput("reset.Count", dCount[0], 32'd0);
    checkOutput("reset.HEX", 32'(dHex[0]), 32'({7'h01, 7'h01}));

    // Full 8-bit sweep with wrap
    for (int e = 1; e <= 256; e++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
      if (e == 'hAB) checkOutput("sweep.HEX_AB", 32'(dHex[0]), 32'({7'h08, 7'h60}));
      if (e == 255) begin
        checkOutput("sweep.Count255", dCount[0], 32'd255);
        checkOutput("sweep.TC255", 32'(tcv[0]), 32'd0);
      end
      if (e == 256) begin
        checkOutput("sweep.Count0", dCount[0], 32'd0);
        checkOutput("sweep.TCwrap", 32'(tcv[0]), 32'd1);
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd0);
    checkOutput("sweep.TCdrop", 32'(tcv[0]), 32'd0);

    // Down from zero with MAX=9
    doClear();
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
    checkOutput("down.Count9", dCount[1], 32'd9);
    checkOutput("down.TC", 32'(tcv[1]), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
    checkOutput("down.Count8", dCount[1], 32'd8);
    checkOutput("down.TCdrop", 32'(tcv[1]), 32'd0);

    // One-shot halt at MAX=5, then resume through load
    doClear();
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
    checkOutput("oneshot.Count5", dCount[2], 32'd5);
    checkOutput("oneshot.notHalted", 32'(hltv[2]), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
    checkOutput("oneshot.Halted", 32'(hltv[2]), 32'd1);
    checkOutput("oneshot.TC", 32'(tcv[2]), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
    checkOutput("oneshot.holdCount", dCount[2], 32'd5);
    checkOutput("oneshot.TCoff", 32'(tcv[2]), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
    checkOutput("oneshot.holdDown", dCount[2], 32'd5);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd2);
    checkOutput("oneshot.load2", dCount[2], 32'd2);
    checkOutput("oneshot.resumeHalt", 32'(hltv[2]), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
    checkOutput("oneshot.resume3", dCount[2], 32'd3);

    // Load beats enable and saturates at MAX=150
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd200);
    checkOutput("clamp.Count150", dCount[3], 32'd150);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd0);
    checkOutput("clamp.hold150", dCount[3], 32'd150);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd3);
    checkOutput("clamp.load3", dCount[3], 32'd3);

    // Asynchronous clear between edges at 0x37
    doClear();
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h36);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
    checkOutput("async.pre37", dCount[0], 32'h37);
    #2 Clear = 1'b1;
    #1;
    checkOutput("async.Count", dCount[0], 32'd0);
    checkOutput("async.TC", 32'(tcv[0]), 32'd0);
    checkOutput("async.HEX", 32'(dHex[0]), 32'({7'h01, 7'h01}));
    @(negedge Clock);
    Clear = 1'b0;

    // Ten-bit display padding and alternating direction
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h3FF);
    checkOutput("w10.Count3FF", dCount[4], 32'h3FF);
    checkOutput("w10.HEX3FF", 32'(dHex[4]), 32'({7'h06, 7'h38, 7'h38}));
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h100);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
    checkOutput("w10.up101", dCount[4], 32'h101);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
    checkOutput("w10.down100", dCount[4], 32'h100);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
    checkOutput("w10.downFF", dCount[4], 32'h0FF);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
    checkOutput("w10.up100", dCount[4], 32'h100);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0)
        doClear();
      else
        applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 15) == 0), 10'($urandom));
    end

    @(negedge Clock);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
